// File: rtl/score_pkg.sv
// Shared constants and types for the pong scoreboard: segment blanking,
// winner encodings, HEX digit indices and a BCD conversion helper.
package score_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] BCD_MAX   = 8'h99;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_L    = 2'b01,
    WIN_R    = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_e;

  localparam logic [1:0] DIG_R1  = 2'd0;
  localparam logic [1:0] DIG_R10 = 2'd1;
  localparam logic [1:0] DIG_L1  = 2'd2;
  localparam logic [1:0] DIG_L10 = 2'd3;

  // Binary 0..99 to packed two-digit BCD {tens, ones}
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/score_display_ctrl_bcd2.sv
// Two-digit BCD counter with synchronous clear and saturation at 99.
// count_next exposes the value the register takes at the next edge.
module bcd2_counter
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count,
  output logic [7:0] count_next
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'h00;
    end else if (inc && (count_q != BCD_MAX)) begin
      if (count_q[3:0] == 4'd9) begin
        count_d = {count_q[7:4] + 4'd1, 4'd0};
      end else begin
        count_d = {count_q[7:4], count_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/seven_segment.sv
// Hex-digit to active-low seven-segment decoder, bit6=a .. bit0=g.
// Codes above 9 are not valid BCD and decode to a blank digit.
module seven_segment
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Pong scoreboard: two BCD scores, registered win detection, winner blink,
// and one shared seven-segment decoder scanned round-robin over HEX3..HEX0.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_l_inc,
  input  logic       score_r_inc,
  input  logic       clear,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] score_l,
  output logic [7:0] score_r
);

  localparam logic [7:0]       WIN_BCD  = to_bcd(WIN_SCORE);
  localparam int unsigned      CNT_W    = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic             game_over_q, game_over_d;
  winner_e          winner_q, winner_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e     phase_q, phase_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0][6:0]  hex_q, hex_d;

  logic       inc_l_en, inc_r_en;
  logic [7:0] next_l, next_r;
  logic       hit_l, hit_r;
  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic       blank_digit;

  // Once the game is decided the scores freeze; clear overrides any pulse
  assign inc_l_en = score_l_inc && !game_over_q && !clear;
  assign inc_r_en = score_r_inc && !game_over_q && !clear;

  bcd2_counter u_bcd_l (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc_l_en),
    .clr        (clear),
    .count      (score_l),
    .count_next (next_l)
  );

  bcd2_counter u_bcd_r (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc_r_en),
    .clr        (clear),
    .count      (score_r),
    .count_next (next_r)
  );

  assign hit_l = (next_l == WIN_BCD);
  assign hit_r = (next_r == WIN_BCD);

  always_comb begin
    game_over_d = game_over_q;
    winner_d    = winner_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (clear) begin
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
    end else if (!game_over_q && (hit_l || hit_r)) begin
      game_over_d = 1'b1;
      winner_d    = winner_e'({hit_r, hit_l});
    end
    if (clear || !game_over_q) begin
      blink_cnt_d = '0;
      phase_d     = PHASE_VISIBLE;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d = '0;
      phase_d     = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    nibble = score_r[3:0];
    case (sel_q)
      DIG_R1:  nibble = score_r[3:0];
      DIG_R10: nibble = score_r[7:4];
      DIG_L1:  nibble = score_l[3:0];
      DIG_L10: nibble = score_l[7:4];
      default: nibble = score_r[3:0];
    endcase
  end

  seven_segment u_seg (
    .digit (nibble),
    .seg   (dec_seg)
  );

  // sel[0] marks a tens digit, sel[1] marks the left player's pair
  always_comb begin
    blank_digit = (sel_q[0] && (nibble == 4'd0)) ||
                  ((phase_q == PHASE_HIDDEN) &&
                   (sel_q[1] ? winner_q[0] : winner_q[1]));
    sel_d        = sel_q + 2'd1;
    hex_d        = hex_q;
    hex_d[sel_q] = blank_digit ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
      blink_cnt_q <= '0;
      phase_q     <= PHASE_VISIBLE;
      sel_q       <= 2'd0;
      hex_q       <= {4{SEG_BLANK}};
    end else begin
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      sel_q       <= sel_d;
      hex_q       <= hex_d;
    end
  end

  assign hex0      = hex_q[DIG_R1];
  assign hex1      = hex_q[DIG_R10];
  assign hex2      = hex_q[DIG_L1];
  assign hex3      = hex_q[DIG_L10];
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus pushes the reference
// model's expected outputs per cycle, a negedge monitor pops and compares.
module tb_score_display_ctrl;

  localparam int WIN  = 7;
  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       score_l_inc = 1'b0;
  logic       score_r_inc = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       game_over;
  logic [1:0] winner;
  logic [7:0] score_l, score_r;

  always #5 clk = ~clk;

  score_display_ctrl #(.WIN_SCORE(WIN), .BLINK_DIV(BDIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .score_l_inc (score_l_inc),
    .score_r_inc (score_r_inc),
    .clear       (clear),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .game_over   (game_over),
    .winner      (winner),
    .score_l     (score_l),
    .score_r     (score_r)
  );

  typedef struct packed {
    logic [7:0]  sl;
    logic [7:0]  sr;
    logic        go;
    logic [1:0]  win;
    logic [27:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: integer scores, cycles elapsed since game over
  int         m_l, m_r, m_n, m_cyc;
  bit         m_go;
  logic [1:0] m_win;
  logic [6:0] m_hex [4];

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] bcd(int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_l = 0; m_r = 0; m_n = 0; m_cyc = 0;
    m_go = 1'b0; m_win = 2'b00;
    for (int i = 0; i < 4; i++) m_hex[i] = 7'h7F;
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, " hex0"}, hex0, 7'h7F);
    checkOutput({tag, " hex1"}, hex1, 7'h7F);
    checkOutput({tag, " hex2"}, hex2, 7'h7F);
    checkOutput({tag, " hex3"}, hex3, 7'h7F);
    checkOutput({tag, " game_over"}, game_over, 0);
    checkOutput({tag, " winner"}, winner, 0);
    checkOutput({tag, " score_l"}, score_l, 0);
    checkOutput({tag, " score_r"}, score_r, 0);
  endtask

  task automatic resetDut();
    score_l_inc = 1'b0; score_r_inc = 1'b0; clear = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    modelReset();
    @(posedge clk); #1;
    checkResetState("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, queue result
  task automatic applyStimulus(bit li, bit ri, bit cl);
    int   k, d;
    bit   tens, left, hidden;
    exp_t e;
    score_l_inc = li; score_r_inc = ri; clear = cl;
    k      = m_cyc % 4;
    left   = (k >= 2);
    tens   = (k % 2 == 1);
    d      = left ? m_l : m_r;
    d      = tens ? d / 10 : d % 10;
    hidden = m_go && ((m_n / BDIV) % 2 == 1) && (left ? m_win[0] : m_win[1]);
    m_hex[k] = ((tens && d == 0) || hidden) ? 7'h7F : glyph(d);
    if (cl) begin
      m_l = 0; m_r = 0; m_go = 1'b0; m_win = 2'b00; m_n = 0;
    end else if (!m_go) begin
      if (li && m_l < 99) m_l++;
      if (ri && m_r < 99) m_r++;
      if (m_l == WIN || m_r == WIN) begin
        m_go  = 1'b1;
        m_win = {m_r == WIN, m_l == WIN};
        m_n   = 0;
      end
    end else begin
      m_n++;
    end
    m_cyc++;
    @(posedge clk); #1;
    e.sl  = bcd(m_l);
    e.sr  = bcd(m_r);
    e.go  = m_go;
    e.win = m_win;
    e.hex = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("score_l", score_l, e.sl);
      checkOutput("score_r", score_r, e.sr);
      checkOutput("game_over", game_over, e.go);
      checkOutput("winner", winner, e.win);
      checkOutput("hex0", hex0, e.hex[6:0]);
      checkOutput("hex1", hex1, e.hex[13:7]);
      checkOutput("hex2", hex2, e.hex[20:14]);
      checkOutput("hex3", hex3, e.hex[27:21]);
    end
  end

  initial begin
    int waited;
    bit li, ri, cl;
    $display("[TB] starting score_display_ctrl bench");
    resetDut();
    repeat (6) applyStimulus(0, 0, 0);

    // Carry from 9 to 10 on the right score
    repeat (10) begin
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
    end
    repeat (6) applyStimulus(0, 0, 0);

    // Left win, ignored extra point, then blinking
    applyStimulus(0, 0, 1);
    repeat (7) begin
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
    end
    applyStimulus(1, 0, 0);
    repeat (20) applyStimulus(0, 0, 0);

    // Asynchronous reset in the middle of a cycle while blinking
    #2 rst = 1'b1;
    exp_q.delete();
    #1 checkResetState("async");
    resetDut();

    // Tie at the winning score
    repeat (6) begin
      applyStimulus(1, 1, 0);
      applyStimulus(0, 0, 0);
    end
    applyStimulus(1, 1, 0);
    repeat (12) applyStimulus(0, 0, 0);

    // Clear beats a simultaneous increment
    applyStimulus(1, 0, 1);
    repeat (6) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 1);
    repeat (5) applyStimulus(0, 0, 0);

    repeat (600) begin
      li = ($urandom_range(0, 2) == 0);
      ri = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 40) == 0);
      applyStimulus(li, ri, cl);
    end
    applyStimulus(0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) checkOutput("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
